// File: rtl/ahb_decoder_sn.sv
`default_nettype none
// ============================================================================
// Module   : ahb_decoder_sn
// Brief    : AHB-Lite address decoder, response mux and default error slave
// Revision : 1.0
// ============================================================================
module ahb_decoder_sn #(
    parameter int                   P_NUM        = 4,
    parameter logic [32*P_NUM-1:0]  P_HSEL_START = {32'h3000_0000, 32'h2000_0000,
                                                    32'h1000_0000, 32'h0000_0000},
    parameter logic [32*P_NUM-1:0]  P_HSEL_SIZE  = {4{32'h0001_0000}}
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  REMAP,
    output logic [P_NUM-1:0]      HSEL,
    output logic                  HSELd,
    input  logic [32*P_NUM-1:0]   HRDATA_S,
    input  logic [P_NUM-1:0]      HREADYOUT_S,
    input  logic [P_NUM-1:0]      HRESP_S,
    output logic [31:0]           HRDATA,
    output logic                  HREADY,
    output logic                  HRESP
);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dstate_t;

    dstate_t            state_q, state_d;
    logic               remap_q, remap_d;
    logic [P_NUM:0]     dsel_q, dsel_d;

    logic [P_NUM-1:0]   w_match;
    logic [P_NUM-1:0]   w_prio;
    logic [P_NUM-1:0]   w_hsel;
    logic               w_dflt_ready;
    logic               w_dflt_resp;

    // 33-bit compare so a region can end exactly at 2^32
    for (genvar i = 0; i < P_NUM; i++) begin : g_match
        localparam logic [32:0] c_LO = {1'b0, P_HSEL_START[32*i +: 32]};
        localparam logic [32:0] c_HI = c_LO + {1'b0, P_HSEL_SIZE[32*i +: 32]};
        assign w_match[i] = ({1'b0, HADDR} >= c_LO) && ({1'b0, HADDR} < c_HI);
    end

    // Isolate the lowest set bit: lowest region index wins on overlap
    assign w_prio = w_match & (~w_match + P_NUM'(1));

    if (P_NUM >= 2) begin : g_remap
        always_comb begin
            w_hsel = w_prio;
            if (remap_q) begin
                w_hsel[0] = w_prio[1];
                w_hsel[1] = w_prio[0];
            end
        end
    end else begin : g_noremap
        assign w_hsel = w_prio;
    end

    assign HSEL  = w_hsel;
    assign HSELd = ~|w_hsel;

    assign w_dflt_ready = (state_q != D_ERR1);
    assign w_dflt_resp  = (state_q != D_IDLE);

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (dsel_q[P_NUM]) begin
            HREADY = w_dflt_ready;
            HRESP  = w_dflt_resp;
        end
        for (int i = 0; i < P_NUM; i++) begin
            if (dsel_q[i]) begin
                HRDATA = HRDATA_S[32*i +: 32];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
    end

    // Data-phase select and remap only advance at a completed transfer
    assign dsel_d  = HREADY ? {HSELd, HSEL} : dsel_q;
    assign remap_d = HREADY ? REMAP : remap_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            D_IDLE:  if (HREADY && HSELd && HTRANS[1]) state_d = D_ERR1;
            D_ERR1:  state_d = D_ERR2;
            D_ERR2:  state_d = (HSELd && HTRANS[1]) ? D_ERR1 : D_IDLE;
            default: state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= D_IDLE;
            remap_q <= 1'b0;
            dsel_q  <= {1'b1, {P_NUM{1'b0}}};
        end else begin
            state_q <= state_d;
            remap_q <= remap_d;
            dsel_q  <= dsel_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_decoder_sn.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_decoder_sn
// Brief    : directed bench with a cycle-level reference model of the decoder
// Revision : 1.0
// ============================================================================
module tb_ahb_decoder_sn;

    localparam int NS = 5;
    localparam logic [32*NS-1:0] c_START = {32'hFFFF_0000, 32'h0000_8000,
                                            32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [32*NS-1:0] c_SIZE  = {5{32'h0001_0000}};

    // Region table as plain numbers for the model
    longint m_lo [NS] = '{64'h0, 64'h1000_0000, 64'h2000_0000, 64'h8000, 64'hFFFF_0000};
    longint m_sz [NS] = '{64'h10000, 64'h10000, 64'h10000, 64'h10000, 64'h10000};

    logic              HCLK, HRESETn;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              REMAP;
    logic [NS-1:0]     HSEL;
    logic              HSELd;
    logic [32*NS-1:0]  HRDATA_S;
    logic [NS-1:0]     HREADYOUT_S, HRESP_S;
    logic [31:0]       HRDATA;
    logic              HREADY, HRESP;

    ahb_decoder_sn #(
        .P_NUM        (NS),
        .P_HSEL_START (c_START),
        .P_HSEL_SIZE  (c_SIZE)
    ) u_dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .REMAP       (REMAP),
        .HSEL        (HSEL),
        .HSELd       (HSELd),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_sel   = NS;   // NS means the default slave owns the data phase
    int m_err   = 0;    // 0 none, 1 first error cycle, 2 second error cycle
    bit m_remap = 1'b0;

    function automatic logic [NS-1:0] f_hsel(input logic [31:0] a, input bit rm);
        logic [NS-1:0] s;
        logic          t;
        s = '0;
        for (int i = 0; i < NS; i++)
            if (s == '0 && {32'h0, a} >= m_lo[i] && {32'h0, a} < m_lo[i] + m_sz[i])
                s[i] = 1'b1;
        if (rm) begin
            t    = s[0];
            s[0] = s[1];
            s[1] = t;
        end
        return s;
    endfunction

    function automatic int f_idx(input logic [NS-1:0] s);
        for (int i = 0; i < NS; i++)
            if (s[i]) return i;
        return NS;
    endfunction

    function automatic logic e_ready();
        return (m_sel == NS) ? (m_err != 1) : HREADYOUT_S[m_sel];
    endfunction

    function automatic logic e_resp();
        return (m_sel == NS) ? (m_err != 0) : HRESP_S[m_sel];
    endfunction

    function automatic logic [31:0] e_rdata();
        return (m_sel == NS) ? 32'h0 : HRDATA_S[32*m_sel +: 32];
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_sel   <= NS;
            m_err   <= 0;
            m_remap <= 1'b0;
        end else begin
            if (e_ready()) begin
                m_sel   <= f_idx(f_hsel(HADDR, m_remap));
                m_remap <= REMAP;
            end
            if (m_err == 1)
                m_err <= 2;
            else if (e_ready() && f_hsel(HADDR, m_remap) == '0 && HTRANS[1])
                m_err <= 1;
            else
                m_err <= 0;
        end
    end

    always @(negedge HCLK) begin
        if (check_en && HRESETn) begin
            chk("m_hsel",   32'(HSEL),   32'(f_hsel(HADDR, m_remap)));
            chk("m_hseld",  32'(HSELd),  32'(f_hsel(HADDR, m_remap) == '0));
            chk("m_hready", 32'(HREADY), 32'(e_ready()));
            chk("m_hresp",  32'(HRESP),  32'(e_resp()));
            chk("m_hrdata", HRDATA,      e_rdata());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge HCLK);
        #2;
    endtask

    logic [31:0] ov_addr [7] = '{32'h0000_9000, 32'h0001_0000, 32'h0001_7FFF,
                                 32'h0001_8000, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFE_FFFF};
    logic [4:0]  ov_sel  [7] = '{5'b00001, 5'b01000, 5'b01000, 5'b00000,
                                 5'b10000, 5'b10000, 5'b00000};

    initial begin
        HRESETn     = 1'b0;
        HADDR       = 32'h0;
        HTRANS      = 2'b00;
        REMAP       = 1'b0;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        for (int i = 0; i < NS; i++) HRDATA_S[32*i +: 32] = 32'hCAFE_0000 | 32'(i);
        repeat (3) @(posedge HCLK);
        #2;

        // reset then idle
        HRESETn  = 1'b1;
        HADDR    = 32'h1000_0004;
        check_en = 1'b1;
        #1;
        chk("rst_hready", 32'(HREADY), 32'h1);
        chk("rst_hresp",  32'(HRESP),  32'h0);
        chk("rst_hrdata", HRDATA,      32'h0);
        chk("rst_hsel",   32'(HSEL),   32'h02);

        // mapped read with one wait state
        step(); HADDR = 32'h2000_0010; HTRANS = 2'b10; #1;
        chk("rd_hsel", 32'(HSEL), 32'h04);
        step(); HTRANS = 2'b00; HREADYOUT_S = 5'b11011; #1;
        chk("rd_wait", 32'(HREADY), 32'h0);
        step(); HREADYOUT_S = '1; #1;
        chk("rd_ready", 32'(HREADY), 32'h1);
        chk("rd_data",  HRDATA,      32'hCAFE_0002);
        chk("rd_resp",  32'(HRESP),  32'h0);

        // unmapped access, then an IDLE to the same address
        step(); HADDR = 32'h4000_0000; HTRANS = 2'b10; #1;
        chk("um_hseld", 32'(HSELd), 32'h1);
        step(); HTRANS = 2'b00; #1;
        chk("um_e1", {30'h0, HREADY, HRESP}, 32'b01);
        step(); #1;
        chk("um_e2", {30'h0, HREADY, HRESP}, 32'b11);
        step(); #1;
        chk("um_idle_ok", {30'h0, HREADY, HRESP}, 32'b10);

        // back-to-back unmapped
        step(); HTRANS = 2'b10;
        step(); #1; chk("bb_e1a", {30'h0, HREADY, HRESP}, 32'b01);
        step(); #1; chk("bb_e2a", {30'h0, HREADY, HRESP}, 32'b11);
        step(); HTRANS = 2'b00; #1; chk("bb_e1b", {30'h0, HREADY, HRESP}, 32'b01);
        step(); #1; chk("bb_e2b", {30'h0, HREADY, HRESP}, 32'b11);
        step(); #1; chk("bb_idle", {30'h0, HREADY, HRESP}, 32'b10);

        // remap changes only at a transfer boundary
        step(); HADDR = 32'h0000_0100; HTRANS = 2'b10; #1;
        chk("rm_hsel0", 32'(HSEL), 32'h01);
        step(); HTRANS = 2'b00; HREADYOUT_S = 5'b11110; REMAP = 1'b1; #1;
        chk("rm_wait1", 32'(HREADY), 32'h0);
        step(); #1;
        chk("rm_hold", 32'(HSEL), 32'h01);
        step(); HREADYOUT_S = '1; #1;
        chk("rm_done", HRDATA, 32'hCAFE_0000);
        step(); HTRANS = 2'b10; #1;
        chk("rm_hsel1", 32'(HSEL), 32'h02);
        step(); HTRANS = 2'b00; REMAP = 1'b0; #1;
        chk("rm_data1", HRDATA, 32'hCAFE_0001);
        step(); #1;
        chk("rm_off", 32'(HSEL), 32'h01);

        // overlap and edge addresses
        for (int k = 0; k < 7; k++) begin
            step(); HADDR = ov_addr[k]; #1;
            chk("ov_hsel",  32'(HSEL),  32'(ov_sel[k]));
            chk("ov_hseld", 32'(HSELd), 32'(ov_sel[k] == 5'b0));
        end

        // slave error passes through
        step(); HADDR = 32'h1000_0000; HTRANS = 2'b10;
        step(); HTRANS = 2'b00; HRESP_S = 5'b00010; #1;
        chk("sl_resp", 32'(HRESP), 32'h1);
        step(); HRESP_S = '0;

        // reset mid-error
        step(); HADDR = 32'h4000_0000; HTRANS = 2'b10;
        step(); HTRANS = 2'b00; #1;
        chk("re_e1", {30'h0, HREADY, HRESP}, 32'b01);
        #1 HRESETn = 1'b0;
        #1;
        chk("re_async", {30'h0, HREADY, HRESP}, 32'b10);
        step(); HRESETn = 1'b1; #1;
        chk("re_rel", {30'h0, HREADY, HRESP}, 32'b10);
        step(); #1;
        chk("re_idle", {30'h0, HREADY, HRESP}, 32'b10);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_decoder_sn.md
# ahb_decoder_sn

Parametrised AHB-Lite address decoder and slave-to-master response multiplexer for 1 to 16 slaves, with an integrated default slave. It sits between the single AHB-Lite master and the slave ports. The block adds three things over a plain two-slave combinational decoder:
- registered data-phase tracking,
- a REMAP that can only change at a transfer boundary,
- a spec-compliant two-cycle ERROR response for unmapped addresses.

## Interface
Parameters:
- P_NUM, 4, number of slaves (1..16).
- P_HSEL_START, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, packed base addresses; slave i at bits [32i+31:32i].
- P_HSEL_SIZE, {4{32'h0001_0000}}, packed region sizes in bytes, same packing; size 0 disables that slave.

Ports:
- HCLK  input  1  bus clock, all state on rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- HADDR  input  32  master address.
- HTRANS  input  2  master transfer type; bit 1 = NONSEQ/SEQ.
- REMAP  input  1  request to swap the decode of slaves 0 and 1.
- HSEL  output  P_NUM  one-hot slave select, address phase.
- HSELd  output  1  default slave selected, address phase.
- HRDATA_S  input  32*P_NUM  packed slave read data.
- HREADYOUT_S  input  P_NUM  slave ready outputs.
- HRESP_S  input  P_NUM  slave responses.
- HRDATA  output  32  muxed read data to the master.
- HREADY  output  1  muxed ready to the master; also drives every slave's HREADY input.
- HRESP  output  1  muxed response to the master.

## Operation
- Region match: match[i] = (HADDR >= START_i) && ({1'b0,HADDR} < START_i + SIZE_i), evaluated in 33 bits so that a region may end at 2^32.
- Overlapping regions: the lowest index wins. The HSEL output is always one-hot or all-zero.
- REMAP:
  - remap_q is loaded from REMAP on a clock edge only when HREADY=1.
  - When remap_q=1 and P_NUM>=2, the decode of region 0 drives HSEL[1] and region 1 drives HSEL[0].
  - When P_NUM=1, REMAP is ignored.
- HSELd = ~|HSEL. HSEL and HSELd are combinational from HADDR and remap_q and are independent of HTRANS.
- Data-phase select dsel (P_NUM+1 bits, one-hot, including the default slave): loaded with {HSELd,HSEL} on each edge with HREADY=1; held while HREADY=0.
- Response mux, combinational from dsel:
  - Slave i selected: HRDATA/HREADY/HRESP come from slave i.
  - Default slave selected: HRDATA=32'h0, with HREADY and HRESP from the default-slave FSM.
- Default-slave FSM, states D_IDLE, D_ERR1, D_ERR2:
  - D_IDLE: HREADY=1, HRESP=0. Goes to D_ERR1 on an edge with HREADY=1 & HSELd=1 & HTRANS[1]=1; otherwise stays.
  - D_ERR1: HREADY=0, HRESP=1. Always goes to D_ERR2.
  - D_ERR2: HREADY=1, HRESP=1. Goes to D_ERR1 if HSELd=1 & HTRANS[1]=1; otherwise goes to D_IDLE.
  - IDLE or BUSY transfers to the default slave get a zero-wait OKAY.
- Outputs after reset:
  - dsel = default slave, FSM = D_IDLE, remap_q = 0.
  - Therefore HREADY=1, HRESP=0, HRDATA=0.
  - HSEL follows HADDR combinationally.

## Timing
- Decode has zero latency: HSEL/HSELd are valid in the same cycle as HADDR.
- The response mux switches one cycle after the address phase completes (the edge with HREADY=1).
- An unmapped NONSEQ/SEQ takes exactly 2 data-phase cycles: ERR1 then ERR2.
- A slave wait state (HREADYOUT_S[i]=0) holds dsel and remap_q, and blocks FSM entry.
- REMAP toggled while HREADY=0 takes effect on the first edge with HREADY=1; the next address phase decodes with the new value.
- Back-to-back unmapped transfers go ERR1, ERR2, ERR1, ERR2 with no idle gap.
- A master that changes HTRANS to IDLE during ERR1 has no effect; the FSM still completes ERR2.
- Asserting HRESETn=0 mid-error forces D_IDLE, the default dsel and remap_q=0 immediately (asynchronous reset).

## Test plan
- Reset then idle: HRESETn low, then high, with HTRANS=IDLE -> HREADY=1, HRESP=0, HRDATA=0; HADDR=0x1000_0004 gives HSEL=4'b0010.
- Mapped read:
  - Stimulus: NONSEQ to 0x2000_0010, slave 2 returns HRDATA_S=0xCAFE_0002 with one wait state.
  - Required: HSEL=4'b0100 in the address phase; HREADY=0 for one cycle, then HREADY=1 with HRDATA=0xCAFE_0002, HRESP=0.
- Unmapped access:
  - Stimulus: NONSEQ to 0x4000_0000.
  - Required: HSELd=1; data phase shows HREADY=0/HRESP=1, then HREADY=1/HRESP=1.
  - An IDLE to the same address gives a zero-wait OKAY.
- Remap boundary:
  - Stimulus: set REMAP=1 during a slave 0 wait state, then NONSEQ to 0x0000_0100.
  - Required: the in-flight transfer completes from slave 0; the new transfer asserts HSEL=4'b0010.
- Overlap and edge addresses:
  - Configuration: region 3 = 0x0000_8000 with size 0x0001_0000 (overlaps region 0).
  - Required: HADDR 0x0000_9000 -> HSEL[0]; 0x0001_0000 -> HSEL[3]; 0x0001_7FFF -> HSEL[3]; 0x0001_8000 -> HSELd.
  - Also, a region at 0xFFFF_0000 with size 0x0001_0000 matches 0xFFFF_FFFF.
- Reset mid-error: assert HRESETn=0 in the ERR1 cycle -> HREADY=1, HRESP=0 immediately; the FSM is in D_IDLE after release.
